// File: rtl/sga_direction_queue.sv
// sga_direction_queue: per-player key edge detector with a small turn FIFO; each step commits one queued turn.
module sga_direction_queue #(
  parameter int PLAYERS = 1,
  parameter int DEPTH = 2,
  parameter int ALLOW_REVERSE = 0,
  parameter logic [1:0] INIT_DIR = 2'b00
) (
  input  logic                 clock,
  input  logic                 restart_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [PLAYERS-1:0]   left,
  input  logic [PLAYERS-1:0]   up,
  input  logic [PLAYERS-1:0]   down,
  input  logic [PLAYERS-1:0]   right,
  input  logic                 step,
  output logic [2*PLAYERS-1:0] direction,
  output logic [PLAYERS-1:0]   pending,
  output logic [PLAYERS-1:0]   played,
  output logic [PLAYERS-1:0]   overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  genvar p;
  for (p = 0; p < PLAYERS; p++) begin : g_p
    logic [3:0] lvl, prev, rise;
    logic [1:0] q [DEPTH];
    logic [PW-1:0] rd, wr;
    logic [CW-1:0] cnt;
    logic [1:0] dir, cand, last;
    logic ok, pop, room, push, pl, ovf;
    assign lvl  = {left[p], up[p], down[p], right[p]};
    assign rise = lvl & ~prev;
    always_comb begin
      cand = rise[3] ? 2'b01 : rise[2] ? 2'b11 : rise[1] ? 2'b10 : 2'b00;
      last = (cnt != '0) ? q[wr - PW'(1)] : dir;
      ok   = enable && (|rise) && cand != last && (ALLOW_REVERSE != 0 || cand != (last ^ 2'b01));
      pop  = step && cnt != '0;
      room = cnt < CW'(DEPTH) || pop;
      push = ok && room;
    end
    always_ff @(posedge clock)
      if (push && !clear) q[wr] <= cand;
    // previous levels reset high so a key held through reset release is not a press
    always_ff @(posedge clock or negedge restart_n)
      if (!restart_n) begin
        prev <= '1;
        rd   <= '0;
        wr   <= '0;
        cnt  <= '0;
        dir  <= INIT_DIR;
        pl   <= 1'b0;
        ovf  <= 1'b0;
      end else if (clear) begin
        prev <= lvl;
        rd   <= '0;
        wr   <= '0;
        cnt  <= '0;
        dir  <= INIT_DIR;
        pl   <= 1'b0;
        ovf  <= 1'b0;
      end else begin
        prev <= lvl;
        if (pop) begin
          dir <= q[rd];
          rd  <= rd + PW'(1);
        end
        if (push) wr <= wr + PW'(1);
        cnt <= cnt + CW'(push) - CW'(pop);
        pl  <= push;
        if (ok && !room) ovf <= 1'b1;
      end
    assign direction[2*p +: 2] = dir;
    assign pending[p]  = cnt != '0;
    assign played[p]   = pl;
    assign overflow[p] = ovf;
  end
endmodule

// File: doc/sga_direction_queue.md
# sga_direction_queue

Parametrised per-player direction input controller for the Snake Game Arcade. It replaces the single-player direction latch inside the control unit. Per player, it detects key presses and rejects duplicate and reverse turns against the last queued direction. Accepted turns are buffered in a small FIFO, and one turn is committed per snake move, so quick two-key combos between moves are not lost. The control unit drives `enable` while in its wait state and pulses `step` when the head position is registered.

## Interface
Parameters:
- PLAYERS, 1, number of independent snakes (1..4)
- DEPTH, 2, turn queue entries per player (power of 2, 2..8)
- ALLOW_REVERSE, 0, 1 = 180° turns are accepted
- INIT_DIR, 2'b00, direction after reset/clear

Direction encoding: RIGHT 00, LEFT 01, DOWN 10, UP 11. The opposite direction is `d ^ 2'b01`.

Ports:
- clock  in  1  system clock, all state on rising edge
- restart_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous re-initialise (new game)
- enable  in  1  key edges accepted only while high
- left, up, down, right  in  PLAYERS each  debounced key levels, bit p = player p
- step  in  1  one-cycle pulse: commit one queued turn per player
- direction  out  2*PLAYERS  committed direction, player p at [2p+1:2p]
- pending  out  PLAYERS  queue of player p non-empty
- played  out  PLAYERS  one-cycle pulse: a turn was enqueued
- overflow  out  PLAYERS  sticky: an accepted turn was dropped because the queue was full

## Operation
- **Edge detect:** a registered previous level is kept per key. A press is a rising edge (level 1, previous 0). Previous levels update every cycle, regardless of `enable`.
- **Priority:** with several rising edges in one cycle for a player, the candidate is left > up > down > right. The other edges are discarded.
- **Reference direction:** `last` = the tail entry if the queue is non-empty, else `direction`.
- **Rejection:** the candidate is rejected if it equals `last`. It is also rejected if ALLOW_REVERSE=0 and it equals `last ^ 01`. A rejected candidate has no effect on state or outputs.
- **Push:** an accepted candidate is pushed if count < DEPTH, or if `step` is high in the same cycle and count > 0. Otherwise it is dropped and `overflow[p]` is set.
- **played:** `played[p]` is high for exactly the cycle after a push.
- **Pop:** on `step` with count > 0, `direction` takes the head entry and the head is popped. With count = 0, `direction` holds.
- **Push and pop in the same cycle:** validity is checked against the pre-edge `last`. The count is unchanged, except from empty, where the pop is a no-op and count becomes 1. There is no bypass: a turn pushed into an empty queue takes effect on the next `step`.
- **Precedence:** clear > step > push. On clear:
  - queues are emptied
  - `direction` = INIT_DIR for all players
  - `overflow` and `played` = 0
  - previous key levels load the current inputs, so a held key does not register
- **Reset** (restart_n low, asynchronous):
  - `direction` = INIT_DIR replicated
  - `pending`, `played`, `overflow` = 0
  - queue pointers and count = 0
  - previous key levels = all 1s (a key held through reset release is not a press)
- **Independence:** players are fully independent. `step`, `clear` and `enable` are shared.

## Timing
- Key high at edge k with previous 0, enable high at edge k → entry pushed at edge k. `pending` and `played` are high from after edge k; `played` falls after edge k+1.
- `step` sampled at edge j → `direction` is updated after edge j. Minimum key-to-direction latency is one push edge plus one later `step` edge. Same-edge push and step do not commit the new key.
- `pending` and `overflow` are registered. No combinational path runs from inputs to outputs.
- Queue count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- restart_n deassertion is synchronous to clock by the system reset synchroniser (external).

## Test plan
- **Reset defaults:** restart_n low with up held, then released, enable=1, PLAYERS=2 → direction=4'b0000, pending=00, played=00, no push while up stays held.
- **Combo:** direction RIGHT, press up at edge 5, press left at edge 8, step at 10 and 12 → queue holds [UP, LEFT]. direction=UP after edge 10 and LEFT after edge 12. pending falls after edge 12.
- **Reverse and duplicate:** direction RIGHT with empty queue, ALLOW_REVERSE=0:
  - press left → no push, played stays 0
  - press right → no push
  - with ALLOW_REVERSE=1, press left → push, then step gives direction=01
- **Overflow:** DEPTH=2, push UP, LEFT, DOWN without step → DOWN dropped, overflow[0]=1 sticky. A step plus a new press of UP in the same cycle → pop UP, push UP accepted (checked against tail LEFT), count stays 2.
- **Simultaneous keys and enable:**
  - left and down rising in the same cycle → LEFT chosen
  - a press while enable=0 → ignored
  - key held across the enable rise → no push
- **Clear mid-game:** queue holds 2 entries, overflow=1, clear and step pulsed in the same cycle → direction=INIT_DIR, pending=0, overflow=0 after that edge.
